// File: rtl/svc_rv_st_split.sv
// rtl/svc_rv_st_split.sv - RV32 store lane shifter and strobe generator with word-boundary split
module svc_rv_st_split #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [AW-1:0]   st_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      st_funct3,
    output logic            m_wr_valid,
    input  logic            m_wr_ready,
    output logic [AW-1:0]   m_wr_addr,
    output logic [XLEN-1:0] m_wr_data,
    output logic [3:0]      m_wr_strb,
    output logic            st_done,
    output logic            st_err
);

    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    state_t            state;
    logic [XLEN-1:0]   hi_data;
    logic [3:0]        hi_strb;
    logic [AW-1:0]     hi_addr;

    logic              legal;
    logic [XLEN-1:0]   byte_mask;
    logic [3:0]        size_mask;
    logic [2*XLEN-1:0] wide_data;
    logic [7:0]        wide_strb;
    logic [AW-1:0]     base;

    assign st_ready = (state == IDLE);

    always_comb begin
        legal     = 1'b1;
        byte_mask = '0;
        size_mask = 4'h0;
        case (st_funct3)
            3'b000: begin byte_mask = XLEN'(32'h0000_00FF); size_mask = 4'h1; end
            3'b001: begin byte_mask = XLEN'(32'h0000_FFFF); size_mask = 4'h3; end
            3'b010: begin byte_mask = '1;                   size_mask = 4'hF; end
            default: legal = 1'b0;
        endcase
        // Shift into a double-width window; the upper half is the spill into the next word.
        wide_data = {{XLEN{1'b0}}, st_data & byte_mask} << {st_addr[1:0], 3'b000};
        wide_strb = {4'h0, size_mask} << st_addr[1:0];
        base      = {st_addr[AW-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_wr_valid <= 1'b0;
            m_wr_addr  <= '0;
            m_wr_data  <= '0;
            m_wr_strb  <= 4'h0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            hi_data    <= '0;
            hi_strb    <= 4'h0;
            hi_addr    <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_valid) begin
                        if (legal) begin
                            m_wr_valid <= 1'b1;
                            m_wr_addr  <= base;
                            m_wr_data  <= wide_data[XLEN-1:0];
                            m_wr_strb  <= wide_strb[3:0];
                            hi_data    <= wide_data[2*XLEN-1:XLEN];
                            hi_strb    <= wide_strb[7:4];
                            hi_addr    <= base + AW'(4);
                            state      <= WR0;
                        end else begin
                            st_done <= 1'b1;
                            st_err  <= 1'b1;
                        end
                    end
                end
                WR0: begin
                    if (m_wr_ready) begin
                        if (hi_strb != 4'h0) begin
                            m_wr_addr <= hi_addr;
                            m_wr_data <= hi_data;
                            m_wr_strb <= hi_strb;
                            state     <= WR1;
                        end else begin
                            m_wr_valid <= 1'b0;
                            st_done    <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                WR1: begin
                    if (m_wr_ready) begin
                        m_wr_valid <= 1'b0;
                        st_done    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/svc_rv_st_split.md
# svc_rv_st_split

Store-side counterpart of the load formatter: accepts RV32 store requests (SB/SH/SW) from the execute/memory stage, lane-shifts the register data, and generates byte strobes. It issues word-aligned write beats to the data-memory port over a valid/ready handshake. A store that crosses a 32-bit word boundary is split into two sequential beats. Sits between the pipeline's memory stage and the data bus.

## Interface
- XLEN, 32, data width; only 32 is supported.
- AW, 32, byte-address width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous and active-low
- st_valid  in  1  store request valid
- st_ready  out  1  block can accept a request
- st_addr  in  AW  byte address
- st_data  in  XLEN  rs2 value
- st_funct3  in  3  000=SB, 001=SH, 010=SW; all other codes are illegal
- m_wr_valid  out  1  write beat valid
- m_wr_ready  in  1  memory accepts beat
- m_wr_addr  out  AW  word-aligned beat address (bits [1:0] are always 0)
- m_wr_data  out  XLEN  lane-shifted write data
- m_wr_strb  out  4  byte enables; bit i enables m_wr_data[8i+7:8i]
- st_done  out  1  one-cycle pulse when a store completes
- st_err  out  1  one-cycle pulse, coincident with st_done, when funct3 is illegal

## Operation
- States: IDLE, WR0, WR1. st_ready = (state == IDLE).
- Accept on st_valid && st_ready. Registered at accept:
  - off = st_addr[1:0].
  - mask = 0x1 (SB), 0x3 (SH) or 0xF (SW).
  - 8-bit wide strobe = mask << off.
  - 64-bit wide data = (st_data & byte-mask) << (8*off).
  - base = st_addr with bits [1:0] cleared.
- Beat 0: addr = base, data = wide[31:0], strb = wide_strb[3:0].
- Beat 1 is issued only if wide_strb[7:4] != 0: addr = base + 4 (mod 2^AW, wraps to 0), data = wide[63:32], strb = wide_strb[7:4].
- Data bytes in lanes with a disabled strobe are driven 0.
- State transitions:
  - IDLE -> WR0 on a legal accept.
  - WR0 -> WR1 on handshake if a split is needed; otherwise WR0 -> IDLE.
  - WR1 -> IDLE on handshake.
- Illegal funct3: the request is accepted, no bus beat is issued, and the state stays IDLE. st_done and st_err pulse in the next cycle.
- Exactly one st_done pulse per accepted request.

## Timing
- Reset values, applied immediately on rst_n low regardless of clk: state = IDLE, m_wr_valid = 0, m_wr_addr = 0, m_wr_data = 0, m_wr_strb = 0, st_done = 0, st_err = 0.
- All outputs are registered. st_ready is decoded from registered state.
- Request accepted at edge T: m_wr_valid = 1 during cycle T+1.
- While m_wr_valid = 1 && m_wr_ready = 0, m_wr_valid, m_wr_addr, m_wr_data and m_wr_strb hold stable.
- Beat 1 is presented in the cycle after the beat-0 handshake. There is no idle gap.
- st_done is high for exactly one cycle after the final-beat handshake edge. In that cycle the state is IDLE, so a new request can be accepted in the same cycle.
- Best-case throughput: one unsplit store every 2 cycles; one split store every 3 cycles.
- Reset asserted mid-transaction (WR0 or WR1): the transaction is abandoned, no st_done is produced, and no further beats are issued after release.

## Test plan
- SB, addr 0x1003, data 0x12345678, m_wr_ready=1 -> single beat: addr 0x1000, data 0x78000000, strb 1000. st_done one cycle after the handshake.
- SH, addr 0x2002, data 0xAAAABEEF -> single beat: addr 0x2000, data 0xBEEF0000, strb 1100.
- SW, addr 0x3001, data 0x11223344 -> two beats, one st_done:
  - beat 0: addr 0x3000, data 0x22334400, strb 1110
  - beat 1: addr 0x3004, data 0x00000011, strb 0001
- SH, addr 0xFFFFFFFF, data 0x0000ABCD -> two beats, address wrap:
  - beat 0: addr 0xFFFFFFFC, data 0xCD000000, strb 1000
  - beat 1: addr 0x00000000, data 0x000000AB, strb 0001
- SW, addr 0x4000, m_wr_ready held low 3 cycles -> m_wr_valid/addr/data/strb stable through the stall, st_ready=0, no st_done until the handshake. Then issue funct3=011 -> no beat; st_done=1 and st_err=1 for one cycle.
- Split SW with rst_n pulled low while in WR1 (m_wr_ready=0) -> outputs go to 0 before the next clk edge. After release: st_ready=1, no beat, no st_done.
